// File: rtl/shift_add_mult.sv
// Sequential 4x4 unsigned multiplier using one shift-and-add iteration per clock.
// A single four_bit_addr instance performs every partial-product accumulation.

module four_bit_addr (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Co
);

  logic w_c1;
  logic w_c2;
  logic w_c3;

  // Plain ripple-carry chain; explicit carries keep the path easy to follow.
  assign Sum[0] = A[0] ^ B[0] ^ Cin;
  assign w_c1   = (A[0] & B[0]) | (Cin & (A[0] ^ B[0]));
  assign Sum[1] = A[1] ^ B[1] ^ w_c1;
  assign w_c2   = (A[1] & B[1]) | (w_c1 & (A[1] ^ B[1]));
  assign Sum[2] = A[2] ^ B[2] ^ w_c2;
  assign w_c3   = (A[2] & B[2]) | (w_c2 & (A[2] ^ B[2]));
  assign Sum[3] = A[3] ^ B[3] ^ w_c3;
  assign Co     = (A[3] & B[3]) | (w_c3 & (A[3] ^ B[3]));

endmodule

module shift_add_mult (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       strt,
  input  logic [3:0] mcand,
  input  logic [3:0] mplier,
  output logic [7:0] prod,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] r_state;
  logic [3:0] r_mcand;
  logic [7:0] r_prod;
  logic [1:0] r_cnt;

  logic [3:0] w_addend;
  logic [3:0] w_sum;
  logic       w_co;

  // Upper nibble accumulates; lower nibble holds the multiplier bits not yet consumed.
  assign w_addend = r_prod[0] ? r_mcand : 4'h0;

  four_bit_addr u_addr (
    .A   (r_prod[7:4]),
    .B   (w_addend),
    .Cin (1'b0),
    .Sum (w_sum),
    .Co  (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mcand <= 4'h0;
      r_prod  <= 8'h00;
      r_cnt   <= 2'd0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (strt) begin
            r_mcand <= mcand;
            r_prod  <= {4'h0, mplier};
            r_cnt   <= 2'd0;
            r_state <= MULT;
          end
        end
        MULT: begin
          // The adder carry shifts into bit 7, so the 9-bit partial sum is never truncated.
          r_prod <= {w_co, w_sum, r_prod[3:1]};
          r_cnt  <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_state <= DONE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign prod = r_prod;
  assign busy = (r_state == MULT);
  assign done = (r_state == DONE);

endmodule
